// File: rtl/vga_tile_renderer_if.sv
// Pixel-enable, tile-map write, player overlay, palette and video output bundle
// shared by the tile renderer and whatever drives it.
interface vga_tile_renderer_if #(
    parameter int COLOR_W    = 4,
    parameter int MAP_W_LOG2 = 4,
    parameter int MAP_H_LOG2 = 4
);
    logic                               pix_en;
    logic                               map_we;
    logic [MAP_W_LOG2+MAP_H_LOG2-1:0]   map_waddr;
    logic                               map_wdata;
    logic [MAP_W_LOG2-1:0]              player_x;
    logic [MAP_H_LOG2-1:0]              player_y;
    logic                               player_vld;
    logic [3*COLOR_W-1:0]               wall_color;
    logic [3*COLOR_W-1:0]               path_color;
    logic [3*COLOR_W-1:0]               player_color;
    logic [3*COLOR_W-1:0]               bg_color;
    logic [COLOR_W-1:0]                 red;
    logic [COLOR_W-1:0]                 green;
    logic [COLOR_W-1:0]                 blue;
    logic                               hsync;
    logic                               vsync;
    logic                               de;
    logic                               frame_start;
    logic                               init_busy;

    modport master (
        output pix_en, map_we, map_waddr, map_wdata,
        output player_x, player_y, player_vld,
        output wall_color, path_color, player_color, bg_color,
        input  red, green, blue, hsync, vsync, de, frame_start, init_busy
    );

    modport slave (
        input  pix_en, map_we, map_waddr, map_wdata,
        input  player_x, player_y, player_vld,
        input  wall_color, path_color, player_color, bg_color,
        output red, green, blue, hsync, vsync, de, frame_start, init_busy
    );
endinterface

// File: rtl/vga_tile_renderer.sv
// Configurable VGA timing generator with a 1-bit wall/path tile map and a
// single player-tile overlay; colour and sync leave a 2-tick pixel pipeline.
module vga_tile_renderer #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit SYNC_POL   = 1'b0,
    parameter int TILE_SHIFT = 5,
    parameter int MAP_W_LOG2 = 4,
    parameter int MAP_H_LOG2 = 4,
    parameter int COLOR_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    vga_tile_renderer_if.slave bus
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int AW       = MAP_W_LOG2 + MAP_H_LOG2;
    localparam int MAP_N    = 1 << AW;
    localparam int MAP_COLS = 1 << MAP_W_LOG2;
    localparam int MAP_ROWS = 1 << MAP_H_LOG2;
    localparam int CW3      = 3 * COLOR_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   init_addr_reg, init_addr_next;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            wr_data;
    logic            mem [MAP_N];

    logic [HW-1:0]   h_cnt_reg;
    logic [VW-1:0]   v_cnt_reg;
    logic [31:0]     h_tile, v_tile;
    logic [AW-1:0]   rd_addr;
    logic            in_map, de_now, hs_now, vs_now, fs_now;

    logic [MAP_W_LOG2-1:0] s1_col_reg, shadow_x_reg;
    logic [MAP_H_LOG2-1:0] s1_row_reg, shadow_y_reg;
    logic            shadow_vld_reg;
    logic            s1_in_map_reg, s1_de_reg, s1_hs_reg, s1_vs_reg, s1_fs_reg;
    logic            map_rd_reg;
    logic [CW3-1:0]  color_reg, color_next;
    logic            hs_reg, vs_reg, de_reg, fs_reg;

    // Init walks every address writing "wall"; host writes are only accepted in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= INIT;
            init_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            init_addr_reg <= init_addr_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        init_addr_next = init_addr_reg;
        wr_en          = 1'b0;
        wr_addr        = bus.map_waddr;
        wr_data        = bus.map_wdata;
        case (state_reg)
            INIT: begin
                wr_en   = 1'b1;
                wr_addr = init_addr_reg;
                wr_data = 1'b1;
                if (init_addr_reg == AW'(MAP_N - 1))
                    state_next = RUN;
                else
                    init_addr_next = init_addr_reg + 1'b1;
            end
            RUN:     wr_en = bus.map_we;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Read-first: a same-clock write to this address is seen on the next scan.
    always_ff @(posedge clk) begin
        if (bus.pix_en)
            map_rd_reg <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (bus.pix_en) begin
            if (h_cnt_reg == HW'(H_TOTAL - 1)) begin
                h_cnt_reg <= '0;
                v_cnt_reg <= (v_cnt_reg == VW'(V_TOTAL - 1)) ? '0 : v_cnt_reg + 1'b1;
            end else begin
                h_cnt_reg <= h_cnt_reg + 1'b1;
            end
        end
    end

    assign h_tile  = 32'(h_cnt_reg) >> TILE_SHIFT;
    assign v_tile  = 32'(v_cnt_reg) >> TILE_SHIFT;
    assign rd_addr = {v_tile[MAP_H_LOG2-1:0], h_tile[MAP_W_LOG2-1:0]};
    assign in_map  = (h_tile < 32'(MAP_COLS)) && (v_tile < 32'(MAP_ROWS));
    assign de_now  = (32'(h_cnt_reg) < 32'(H_ACTIVE)) && (32'(v_cnt_reg) < 32'(V_ACTIVE));
    assign hs_now  = (32'(h_cnt_reg) >= 32'(H_ACTIVE + H_FP)) &&
                     (32'(h_cnt_reg) <  32'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_now  = (32'(v_cnt_reg) >= 32'(V_ACTIVE + V_FP)) &&
                     (32'(v_cnt_reg) <  32'(V_ACTIVE + V_FP + V_SYNC));
    assign fs_now  = (h_cnt_reg == '0) && (v_cnt_reg == '0);

    // Player position is latched at pixel (0,0) so the overlay never tears mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_x_reg   <= '0;
            shadow_y_reg   <= '0;
            shadow_vld_reg <= 1'b0;
        end else if (bus.pix_en && fs_now) begin
            shadow_x_reg   <= bus.player_x;
            shadow_y_reg   <= bus.player_y;
            shadow_vld_reg <= bus.player_vld;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_col_reg    <= '0;
            s1_row_reg    <= '0;
            s1_in_map_reg <= 1'b0;
            s1_de_reg     <= 1'b0;
            s1_hs_reg     <= ~SYNC_POL;
            s1_vs_reg     <= ~SYNC_POL;
            s1_fs_reg     <= 1'b0;
            color_reg     <= '0;
            hs_reg        <= ~SYNC_POL;
            vs_reg        <= ~SYNC_POL;
            de_reg        <= 1'b0;
            fs_reg        <= 1'b0;
        end else if (bus.pix_en) begin
            s1_col_reg    <= h_tile[MAP_W_LOG2-1:0];
            s1_row_reg    <= v_tile[MAP_H_LOG2-1:0];
            s1_in_map_reg <= in_map;
            s1_de_reg     <= de_now;
            s1_hs_reg     <= hs_now ? SYNC_POL : ~SYNC_POL;
            s1_vs_reg     <= vs_now ? SYNC_POL : ~SYNC_POL;
            s1_fs_reg     <= fs_now;
            color_reg     <= color_next;
            hs_reg        <= s1_hs_reg;
            vs_reg        <= s1_vs_reg;
            de_reg        <= s1_de_reg;
            fs_reg        <= s1_fs_reg;
        end
    end

    always_comb begin
        color_next = '0;
        if (!s1_de_reg || state_reg == INIT)
            color_next = '0;
        else if (!s1_in_map_reg)
            color_next = bus.bg_color;
        else if (shadow_vld_reg && s1_col_reg == shadow_x_reg && s1_row_reg == shadow_y_reg)
            color_next = bus.player_color;
        else if (map_rd_reg)
            color_next = bus.wall_color;
        else
            color_next = bus.path_color;
    end

    assign bus.red         = color_reg[CW3-1:2*COLOR_W];
    assign bus.green       = color_reg[2*COLOR_W-1:COLOR_W];
    assign bus.blue        = color_reg[COLOR_W-1:0];
    assign bus.hsync       = hs_reg;
    assign bus.vsync       = vs_reg;
    assign bus.de          = de_reg;
    assign bus.frame_start = fs_reg;
    assign bus.init_busy   = (state_reg == INIT);
endmodule

// File: tb/tb_vga_tile_renderer.sv
// Randomised scoreboard bench for vga_tile_renderer on a shrunken screen: a
// pixel-level reference model queues expected outputs, a monitor checks them.
module tb_vga_tile_renderer;
    localparam int H_ACTIVE = 40, H_FP = 4, H_SYNC = 6, H_BP = 6;
    localparam int V_ACTIVE = 24, V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam bit POL      = 1'b0;
    localparam int TS       = 2;
    localparam int MWL      = 3;
    localparam int MHL      = 2;
    localparam int CW       = 4;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;
    localparam int TILE     = 1 << TS;
    localparam int MAP_COLS = 1 << MWL;
    localparam int MAP_ROWS = 1 << MHL;
    localparam int AW       = MWL + MHL;
    localparam int MAP_N    = 1 << AW;

    typedef struct packed {
        logic [3*CW-1:0] rgb;
        logic            dc;
        logic            hs;
        logic            vs;
        logic            de;
        logic            fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_tile_renderer_if #(.COLOR_W(CW), .MAP_W_LOG2(MWL), .MAP_H_LOG2(MHL)) bus ();

    vga_tile_renderer #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(POL), .TILE_SHIFT(TS), .MAP_W_LOG2(MWL), .MAP_H_LOG2(MHL),
        .COLOR_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t last_exp;

    // Reference model state: scan position, last pixel fetched, player shadow, map.
    int   mh, mv, m;
    bit   s1_valid, s1_known, s1_wall;
    int   s1_h, s1_v;
    bit   sh_vld;
    int   sh_x, sh_y;
    bit   map_known [MAP_N];
    bit   map_val   [MAP_N];

    function automatic exp_t reset_exp();
        exp_t e;
        e.rgb = '0; e.dc = 1'b0; e.hs = ~POL; e.vs = ~POL; e.de = 1'b0; e.fs = 1'b0;
        return e;
    endfunction

    function automatic exp_t pixel_exp(input bit busy);
        exp_t e;
        int col, row;
        e = reset_exp();
        if (s1_valid) begin
            col  = s1_h / TILE;
            row  = s1_v / TILE;
            e.de = (s1_h < H_ACTIVE) && (s1_v < V_ACTIVE);
            e.hs = (s1_h >= H_ACTIVE + H_FP && s1_h < H_ACTIVE + H_FP + H_SYNC) ? POL : ~POL;
            e.vs = (s1_v >= V_ACTIVE + V_FP && s1_v < V_ACTIVE + V_FP + V_SYNC) ? POL : ~POL;
            e.fs = (s1_h == 0) && (s1_v == 0);
            if (!e.de || busy)                             e.rgb = '0;
            else if (col >= MAP_COLS || row >= MAP_ROWS)   e.rgb = bus.bg_color;
            else if (sh_vld && col == sh_x && row == sh_y) e.rgb = bus.player_color;
            else if (!s1_known)                            e.dc  = 1'b1;
            else                                           e.rgb = s1_wall ? bus.wall_color : bus.path_color;
        end
        return e;
    endfunction

    task automatic check_out(input exp_t e, input string tag);
        logic [3*CW-1:0] got;
        got = {bus.red, bus.green, bus.blue};
        checks++;
        if ((!e.dc && got !== e.rgb) || bus.hsync !== e.hs || bus.vsync !== e.vs ||
            bus.de !== e.de || bus.frame_start !== e.fs) begin
            errors++;
            $display("FAIL %s t=%0t: got rgb=%h hs=%b vs=%b de=%b fs=%b, want rgb=%h(dc=%b) hs=%b vs=%b de=%b fs=%b",
                     tag, $time, got, bus.hsync, bus.vsync, bus.de, bus.frame_start,
                     e.rgb, e.dc, e.hs, e.vs, e.de, e.fs);
        end
    endtask

    // One clock of stimulus, issued at a falling edge for the following rising edge.
    task automatic step(input bit en);
        bit busy;
        int addr;
        busy = rst || (m < MAP_N);
        checks++;
        if (bus.init_busy !== busy) begin
            errors++;
            $display("FAIL init_busy t=%0t: got %b want %b", $time, bus.init_busy, busy);
        end
        bus.pix_en = en && !rst;
        if (bus.pix_en) begin
            exp_q.push_back(pixel_exp(busy));
            s1_valid = 1'b1;
            s1_h     = mh;
            s1_v     = mv;
            s1_known = 1'b1;
            s1_wall  = 1'b0;
            if (mh / TILE < MAP_COLS && mv / TILE < MAP_ROWS) begin
                addr     = (mv / TILE) * MAP_COLS + (mh / TILE);
                s1_known = map_known[addr];
                s1_wall  = map_val[addr];
            end
            if (mh == 0 && mv == 0) begin
                sh_vld = bus.player_vld;
                sh_x   = int'(bus.player_x);
                sh_y   = int'(bus.player_y);
            end
            mh++;
            if (mh == H_TOTAL) begin
                mh = 0;
                mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
            end
        end
        if (!rst) begin
            if (m < MAP_N) begin
                map_known[m] = 1'b1;
                map_val[m]   = 1'b1;
                m++;
            end else if (bus.map_we) begin
                map_known[int'(bus.map_waddr)] = 1'b1;
                map_val[int'(bus.map_waddr)]   = bus.map_wdata;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst        = 1'b1;
        bus.pix_en = 1'b0;
        bus.map_we = 1'b0;
        #1;
        check_out(reset_exp(), "reset");
        checks++;
        if (bus.init_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy: got %b want 1", bus.init_busy);
        end
        exp_q.delete();
        last_exp = reset_exp();
        mh = 0; mv = 0; m = 0;
        s1_valid = 1'b0;
        sh_vld = 1'b0; sh_x = 0; sh_y = 0;
        @(negedge clk);
        repeat (cycles) step(1'b0);
        rst = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        bit   en_s, rst_s;
        forever begin
            @(posedge clk);
            en_s  = bus.pix_en;
            rst_s = rst;
            #1;
            if (!rst_s) begin
                if (en_s) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL underflow t=%0t: got a pixel tick, want a queued expectation", $time);
                    end else begin
                        e        = exp_q.pop_front();
                        last_exp = e;
                        check_out(e, "pixel");
                    end
                end else begin
                    check_out(last_exp, "hold");
                end
            end
        end
    end

    initial begin : driver
        int guard;
        bus.pix_en       = 1'b0;
        bus.map_we       = 1'b0;
        bus.map_waddr    = '0;
        bus.map_wdata    = 1'b0;
        bus.player_x     = '0;
        bus.player_y     = '0;
        bus.player_vld   = 1'b0;
        bus.wall_color   = 12'hF00;
        bus.path_color   = 12'h0F0;
        bus.player_color = 12'h00F;
        bus.bg_color     = 12'h555;
        for (int i = 0; i < MAP_N; i++) begin
            map_known[i] = 1'b0;
            map_val[i]   = 1'b0;
        end
        last_exp = reset_exp();

        @(negedge clk);
        do_reset(3);
        repeat (MAP_N + 2 * FRAME) step(1'b1);

        // Carve a path tile at row 2, col 3 and move the player mid-frame.
        bus.map_we    = 1'b1;
        bus.map_waddr = AW'(2 * MAP_COLS + 3);
        bus.map_wdata = 1'b0;
        step(1'b1);
        bus.map_we     = 1'b0;
        bus.player_x   = MWL'(5);
        bus.player_y   = MHL'(2);
        bus.player_vld = 1'b1;
        repeat (FRAME + FRAME / 2) step(1'b1);

        for (int i = 0; i < 4 * FRAME; i++) step(i % 4 == 0);

        for (int i = 0; i < 3 * FRAME; i++) begin
            bus.map_we    = ($urandom_range(0, 29) == 0);
            bus.map_waddr = AW'($urandom_range(0, MAP_N - 1));
            bus.map_wdata = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 499) == 0) begin
                bus.player_x   = MWL'($urandom_range(0, MAP_COLS - 1));
                bus.player_y   = MHL'($urandom_range(0, MAP_ROWS - 1));
                bus.player_vld = 1'($urandom_range(0, 1));
            end
            step($urandom_range(0, 3) != 0);
        end
        bus.map_we = 1'b0;

        // Reset mid-frame; writes attempted during init must be ignored.
        guard = 0;
        while (!(mh == 30 && mv == 20) && guard < 2 * FRAME) begin
            step(1'b1);
            guard++;
        end
        do_reset(2);
        bus.map_we    = 1'b1;
        bus.map_waddr = '0;
        bus.map_wdata = 1'b0;
        repeat (10) step(1'b1);
        bus.map_we = 1'b0;
        repeat (MAP_N + FRAME) step(1'b1);
        repeat (3) step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_tile_renderer.md
Name: vga_tile_renderer

Overview:
Parametrised VGA timing generator plus tile-map renderer for the maze game. It replaces the fixed 640x480 display path with configurable porch and sync timing. It holds an internal wall/path tile map, written through a simple write port, and overlays a single player tile. It produces pipelined RGB, sync, data-enable and frame markers for the board's VGA DAC.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
SYNC_POL, 0, asserted sync level (0 = active-low)
TILE_SHIFT, 5, log2 tile size in pixels (32x32 tiles)
MAP_W_LOG2, 4, log2 map columns
MAP_H_LOG2, 4, log2 map rows
COLOR_W, 4, bits per colour channel

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
pix_en  in  1  pixel-clock enable; timing and video pipeline advance only when high
map_we  in  1  tile write strobe
map_waddr  in  MAP_W_LOG2+MAP_H_LOG2  tile address {row,col}
map_wdata  in  1  1 = wall, 0 = path
player_x  in  MAP_W_LOG2  player tile column
player_y  in  MAP_H_LOG2  player tile row
player_vld  in  1  enable player overlay
wall_color, path_color, player_color, bg_color  in  3*COLOR_W each  {R,G,B} colours
red, green, blue  out  COLOR_W each  pixel colour
hsync, vsync  out  1 each  sync outputs, polarity per SYNC_POL
de  out  1  active-video flag
frame_start  out  1  one-tick pulse marking pixel (0,0)
init_busy  out  1  map initialisation in progress

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 at default); V_TOTAL likewise (525 at default).
- h_cnt advances on every pix_en tick and wraps at H_TOTAL-1 to 0. v_cnt increments on the h wrap and itself wraps at V_TOTAL-1.
- hsync is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the same rule with v_cnt. de = (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE).
- Pipeline, 2 pix_en ticks deep:
  - Stage 1 registers tile col = h_cnt>>TILE_SHIFT and row = v_cnt>>TILE_SHIFT, the in-map flag, and a synchronous map read.
  - Stage 2 registers the colour.
  - hsync, vsync, de and frame_start are delayed by the same 2 ticks so they align with the colour.
- Colour priority at stage 2:
  - !de → 0.
  - init_busy → 0.
  - Outside map (col >= 2^MAP_W_LOG2 or row >= 2^MAP_H_LOG2) → bg_color.
  - player_vld and tile == player shadow → player_color.
  - Map bit 1 → wall_color, else path_color.
- Player shadow: player_x, player_y and player_vld are sampled when the undelayed counters are (0,0) with pix_en high. The overlay is therefore stable for a whole frame.
- Map storage is a 2^(MAP_W_LOG2+MAP_H_LOG2) x 1 RAM and is not reset.
- Initialisation FSM, states INIT and RUN, clocked every clk independent of pix_en:
  - Reset enters INIT.
  - INIT writes 1 to address 0..N-1 on consecutive clks, then enters RUN. init_busy is high throughout INIT (256 clks at default).
  - map_we is ignored in INIT.
- RUN: map_we writes map_wdata at map_waddr on that clk.
  - Read and write to the same address in the same clk returns old data (read-first).
  - A written tile appears on screen from the next scan of that tile.
- Reset values: counters 0, pipeline cleared, red/green/blue = 0, de = 0, frame_start = 0.
  - hsync and vsync sit at the deasserted level (~SYNC_POL).
  - init_busy = 1, player shadow = 0 with vld = 0.
- Reset asserted mid-frame or mid-init: everything returns to the reset values immediately. On release, INIT restarts from address 0.
- pix_en low: counters, pipeline and outputs hold their values. The init FSM and map writes still proceed.

Test Plan:
- Reset release, pix_en tied 1 → init_busy high exactly 256 clks. Over the following frame: hsync low for 96 ticks starting at h=656 (+2 latency); period 800. vsync low on lines 490-491; frame period 420000 ticks; frame_start once per frame.
- After init, no writes → every de pixel with x<512 is wall_color. Pixels x 512-639 are bg_color; de-low pixels are 0.
- Write map_waddr {row 2, col 3} = 0 → next frame, x 96-127 and y 64-95 show path_color; neighbours show wall_color.
- player_x=5, player_y=5, player_vld=1 changed mid-frame → no change in the current frame. Next frame, x 160-191 and y 160-191 show player_color, overriding the wall.
- pix_en toggled 1-of-4 → identical pixel sequence to the tied-1 case, timed per enabled tick; outputs hold between ticks.
- rst pulsed at h=300, v=200 → outputs go to reset values at once. init_busy reasserts for 256 clks; counters restart at (0,0); map is all walls afterwards.
